// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one external 32-bit ALU between
// two requesters, with a private NZCV flag register per requester.
module alu_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [1:0]  req_op_0,
    input  logic [1:0]  req_op_1,
    input  logic        req_usec_0,
    input  logic        req_usec_1,
    input  logic        req_setf_0,
    input  logic        req_setf_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data_0,
    output logic [31:0] rsp_data_1,
    output logic [3:0]  rsp_flags_0,
    output logic [3:0]  rsp_flags_1,
    output logic [3:0]  flags_0,
    output logic [3:0]  flags_1,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_carry,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        usec;
        logic        setf;
    } req_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner;
    logic            last;
    req_t            cap;
    req_t            req0;
    req_t            req1;
    logic [31:0]     res;
    logic [3:0]      rflags;
    logic [1:0][3:0] flg;
    logic [3:0]      own_flags;
    logic [3:0]      new_flags;
    logic            grant;
    logic            win;
    logic            rsp_ack;

    assign req0 = {req_a_0, req_b_0, req_op_0, req_usec_0, req_setf_0};
    assign req1 = {req_a_1, req_b_1, req_op_1, req_usec_1, req_setf_1};

    // Tie goes to the requester that was not served last.
    assign grant = rst_n && (state == IDLE) && (req_valid_0 || req_valid_1);
    assign win   = (req_valid_0 && req_valid_1) ? ~last : req_valid_1;

    assign req_ready_0 = grant && !win;
    assign req_ready_1 = grant && win;

    assign own_flags = flg[owner];
    assign rsp_ack   = owner ? rsp_ready_1 : rsp_ready_0;

    assign alu_in1   = cap.a;
    assign alu_in2   = cap.b;
    assign alu_op    = cap.op;
    assign alu_carry = (state == EXEC) && cap.usec && own_flags[1];

    // Logic ops leave C/V alone; rotate leaves V alone.
    always_comb begin
        new_flags = {alu_n, alu_z, alu_c, alu_v};
        unique case (cap.op)
            2'b10:   new_flags[1:0] = own_flags[1:0];
            2'b11:   new_flags[0] = own_flags[0];
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            cap    <= '0;
            res    <= '0;
            rflags <= '0;
            flg    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                cap   <= win ? req1 : req0;
                owner <= win;
                last  <= win;
            end
            if (state == EXEC) begin
                res    <= alu_out;
                rflags <= new_flags;
                if (cap.setf) flg[owner] <= new_flags;
            end
        end
    end

    assign rsp_valid_0 = (state == RESP) && !owner;
    assign rsp_valid_1 = (state == RESP) && owner;
    assign rsp_data_0  = res;
    assign rsp_data_1  = res;
    assign rsp_flags_0 = rflags;
    assign rsp_flags_1 = rflags;
    assign flags_0     = flg[0];
    assign flags_1     = flg[1];

endmodule
